bp_vc_wb_buffer: RTL and testbench

Writeback buffer sitting directly downstream of the victim cache (VC): accepts lines the VC evicts, drops clean lines, queues dirty lines in FIFO order, and drains them to the UCE over a valid/ready port. Same-tag evictions coalesce in place, and a combinational probe port lets the D$ miss path find a line whose writeback is still pending.

---
 rtl/bp_vc_wb_buffer.sv | 144 ++++++++++++++
 tb/tb_bp_vc_wb_buffer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_vc_wb_buffer.sv
// Writeback buffer downstream of the victim cache: drops clean evictions, queues dirty
// lines FIFO-ordered with same-tag coalescing, drains to the UCE, and answers D$ probes.
module bp_vc_wb_buffer #(
    parameter int block_width = 512,
    parameter int tag_width   = 40,
    parameter int stat_width  = 2,
    parameter int num_entries = 4,
    localparam int cnt_width  = $clog2(num_entries + 1)
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,

    input  logic                   evict_v_i,
    input  logic [block_width-1:0] evict_data_i,
    input  logic [tag_width-1:0]   evict_tag_i,
    input  logic [stat_width-1:0]  evict_stat_i,
    output logic                   evict_ready_o,

    output logic                   wb_v_o,
    output logic [block_width-1:0] wb_data_o,
    output logic [tag_width-1:0]   wb_tag_o,
    output logic [stat_width-1:0]  wb_stat_o,
    input  logic                   wb_ready_i,

    input  logic [tag_width-1:0]   probe_tag_i,
    output logic                   probe_hit_o,
    output logic [block_width-1:0] probe_data_o,
    output logic [stat_width-1:0]  probe_stat_o,

    output logic [cnt_width-1:0]   count_o,
    output logic                   empty_o,
    output logic                   full_o
);

    localparam int ptr_width = $clog2(num_entries);
    localparam logic [ptr_width-1:0] last_ptr = ptr_width'(num_entries - 1);
    localparam logic [cnt_width-1:0] full_cnt = cnt_width'(num_entries);

    logic [num_entries-1:0] valid_q;
    logic [tag_width-1:0]   tag_q  [num_entries];
    logic [stat_width-1:0]  stat_q [num_entries];
    logic [block_width-1:0] data_q [num_entries];
    logic [ptr_width-1:0]   head_q;
    logic [ptr_width-1:0]   tail_q;
    logic [cnt_width-1:0]   count_q;

    logic                 deq;
    logic                 dirty_accept;
    logic                 coal_hit;
    logic [ptr_width-1:0] coal_idx;
    logic                 do_coal;
    logic                 do_app;
    logic                 wr_en;
    logic [ptr_width-1:0] wr_idx;

    function automatic logic [ptr_width-1:0] next_ptr(input logic [ptr_width-1:0] p);
        return (p == last_ptr) ? '0 : p + 1'b1;
    endfunction

    // Flow control looks only at the registered count, so a full buffer refuses even
    // when the head drains in the same cycle.
    assign empty_o       = (count_q == '0);
    assign full_o        = (count_q == full_cnt);
    assign count_o       = count_q;
    assign evict_ready_o = !full_o;
    assign wb_v_o        = !empty_o;

    assign deq          = wb_v_o && wb_ready_i;
    assign dirty_accept = evict_v_i && evict_ready_o && evict_stat_i[0];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        coal_hit = 1'b0;
        coal_idx = '0;
        for (int i = 0; i < num_entries; i++) begin
            // The head leaving this cycle must not absorb the line, or it would be lost.
            if (valid_q[i] && (tag_q[i] == evict_tag_i) &&
                !(deq && (ptr_width'(i) == head_q))) begin
                coal_hit = 1'b1;
                coal_idx = ptr_width'(i);
            end
        end
    end

    assign do_coal = dirty_accept && coal_hit;
    assign do_app  = dirty_accept && !coal_hit;
    assign wr_en   = do_coal || do_app;
    assign wr_idx  = do_coal ? coal_idx : tail_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (deq) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= next_ptr(head_q);
            end
            if (do_app) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= next_ptr(tail_q);
            end
            case ({do_app, deq})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: the payload arrays are not reset; valid bits gate every use of them.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= evict_tag_i;
            stat_q[wr_idx] <= evict_stat_i;
            data_q[wr_idx] <= evict_data_i;
        end
    end

    assign wb_data_o = wb_v_o ? data_q[head_q] : '0;
    assign wb_tag_o  = wb_v_o ? tag_q[head_q]  : '0;
    assign wb_stat_o = wb_v_o ? stat_q[head_q] : '0;

    // Coalescing keeps tags unique, so at most one entry can match here.
    always_comb begin
        probe_hit_o  = 1'b0;
        probe_data_o = '0;
        probe_stat_o = '0;
        for (int i = 0; i < num_entries; i++) begin
            if (valid_q[i] && (tag_q[i] == probe_tag_i)) begin
                probe_hit_o  = 1'b1;
                probe_data_o = data_q[i];
                probe_stat_o = stat_q[i];
            end
        end
    end

    count_matches_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        count_q == cnt_width'($countones(valid_q)));

endmodule

// File: tb/tb_bp_vc_wb_buffer.sv
// Directed bench for bp_vc_wb_buffer: fill/drain, clean drop, coalescing, wrap-around,
// probe behaviour and mid-operation reset, all against hand-computed values.
module tb_bp_vc_wb_buffer;

    localparam int BW = 512;
    localparam int TW = 40;
    localparam int SW = 2;
    localparam int NE = 4;
    localparam int CW = $clog2(NE + 1);

    logic          clk_i = 1'b0;
    logic          reset_n_i;
    logic          evict_v_i;
    logic [BW-1:0] evict_data_i;
    logic [TW-1:0] evict_tag_i;
    logic [SW-1:0] evict_stat_i;
    logic          evict_ready_o;
    logic          wb_v_o;
    logic [BW-1:0] wb_data_o;
    logic [TW-1:0] wb_tag_o;
    logic [SW-1:0] wb_stat_o;
    logic          wb_ready_i;
    logic [TW-1:0] probe_tag_i;
    logic          probe_hit_o;
    logic [BW-1:0] probe_data_o;
    logic [SW-1:0] probe_stat_o;
    logic [CW-1:0] count_o;
    logic          empty_o;
    logic          full_o;

    int checks = 0;
    int errors = 0;

    bp_vc_wb_buffer #(
        .block_width(BW), .tag_width(TW), .stat_width(SW), .num_entries(NE)
    ) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .evict_v_i(evict_v_i), .evict_data_i(evict_data_i), .evict_tag_i(evict_tag_i),
        .evict_stat_i(evict_stat_i), .evict_ready_o(evict_ready_o),
        .wb_v_o(wb_v_o), .wb_data_o(wb_data_o), .wb_tag_o(wb_tag_o),
        .wb_stat_o(wb_stat_o), .wb_ready_i(wb_ready_i),
        .probe_tag_i(probe_tag_i), .probe_hit_o(probe_hit_o),
        .probe_data_o(probe_data_o), .probe_stat_o(probe_stat_o),
        .count_o(count_o), .empty_o(empty_o), .full_o(full_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [BW-1:0] mk(input logic [7:0] t, input logic [7:0] v);
        return {64{t}} ^ BW'(v);
    endfunction

    task automatic evict(input logic [7:0] t, input logic [7:0] v, input logic [SW-1:0] s);
        evict_v_i    = 1'b1;
        evict_tag_i  = TW'(t);
        evict_data_i = mk(t, v);
        evict_stat_i = s;
    endtask

    initial begin
        reset_n_i    = 1'b0;
        evict_v_i    = 1'b0;
        evict_data_i = '0;
        evict_tag_i  = '0;
        evict_stat_i = '0;
        wb_ready_i   = 1'b0;
        probe_tag_i  = '0;

        // Reset values
        #2;
        check("rst_wb_v", wb_v_o, 0);
        check("rst_wb_data", wb_data_o, 0);
        check("rst_count", count_o, 0);
        check("rst_empty", empty_o, 1);
        check("rst_full", full_o, 0);
        check("rst_ready", evict_ready_o, 1);
        check("rst_probe_hit", probe_hit_o, 0);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        step();
        check("idle_wb_v", wb_v_o, 0);
        check("idle_ready", evict_ready_o, 1);
        check("idle_probe_data", probe_data_o, 0);

        // Dirty fill with the UCE stalled
        for (int i = 0; i < 4; i++) begin
            evict(8'h10 + 8'(i), 8'h01, 2'b01);
            check("fill_ready", evict_ready_o, 1);
            step();
            check("fill_count", count_o, i + 1);
        end
        evict_v_i = 1'b0;
        check("full_flag", full_o, 1);
        check("full_ready", evict_ready_o, 0);
        check("full_head_tag", wb_tag_o, 'h10);
        evict(8'h14, 8'h01, 2'b01);
        step();
        check("held_count", count_o, 4);
        evict_v_i  = 1'b0;
        wb_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_v", wb_v_o, 1);
            check("drain_tag", wb_tag_o, 'h10 + i);
            check("drain_data", wb_data_o, mk(8'h10 + 8'(i), 8'h01));
            step();
        end
        check("drain_empty", empty_o, 1);
        check("drain_wb_v", wb_v_o, 0);
        wb_ready_i = 1'b0;

        // Clean eviction is dropped
        evict(8'h20, 8'h02, 2'b00);
        check("clean_ready", evict_ready_o, 1);
        step();
        evict_v_i = 1'b0;
        check("clean_count", count_o, 0);
        check("clean_wb_v", wb_v_o, 0);

        // Coalesce into a non-head entry
        evict(8'h30, 8'hAA, 2'b01); step();
        evict(8'h31, 8'h55, 2'b01); step();
        evict(8'h31, 8'hBB, 2'b11); step();
        evict_v_i = 1'b0;
        check("coal_count", count_o, 2);
        wb_ready_i = 1'b1;
        check("coal_tag0", wb_tag_o, 'h30);
        check("coal_data0", wb_data_o, mk(8'h30, 8'hAA));
        step();
        check("coal_tag1", wb_tag_o, 'h31);
        check("coal_data1", wb_data_o, mk(8'h31, 8'hBB));
        check("coal_stat1", wb_stat_o, 2'b11);
        step();
        check("coal_empty", empty_o, 1);
        wb_ready_i = 1'b0;

        // Same tag as the dequeuing head is appended, not coalesced
        evict(8'h30, 8'hAA, 2'b01); step();
        evict(8'h31, 8'h55, 2'b01); step();
        evict(8'h30, 8'hCC, 2'b01);
        wb_ready_i = 1'b1;
        check("hdq_tag", wb_tag_o, 'h30);
        check("hdq_data", wb_data_o, mk(8'h30, 8'hAA));
        step();
        evict_v_i = 1'b0;
        check("hdq_count", count_o, 2);
        check("hdq_tag1", wb_tag_o, 'h31);
        step();
        check("hdq_tag2", wb_tag_o, 'h30);
        check("hdq_data2", wb_data_o, mk(8'h30, 8'hCC));
        step();
        check("hdq_empty", empty_o, 1);
        wb_ready_i = 1'b0;

        // Coalesce into the head shows up on the payload next cycle
        evict(8'h50, 8'h11, 2'b01); step();
        evict(8'h50, 8'h22, 2'b01); step();
        evict_v_i = 1'b0;
        check("headcoal_count", count_o, 1);
        check("headcoal_data", wb_data_o, mk(8'h50, 8'h22));
        wb_ready_i = 1'b1;
        step();
        check("headcoal_empty", empty_o, 1);

        // Streaming with concurrent drain across pointer wrap
        for (int i = 0; i < 10; i++) begin
            evict(8'h60 + 8'(i), 8'h33, 2'b01);
            step();
            check("wrap_cnt_le1", count_o <= 1, 1);
            check("wrap_tag", wb_tag_o, 'h60 + i);
            check("wrap_data", wb_data_o, mk(8'h60 + 8'(i), 8'h33));
        end
        evict_v_i = 1'b0;
        step();
        check("wrap_empty", empty_o, 1);
        wb_ready_i = 1'b0;

        // Probe
        evict(8'h40, 8'h77, 2'b01); step();
        evict_v_i   = 1'b0;
        probe_tag_i = TW'('h40);
        #1;
        check("probe_hit", probe_hit_o, 1);
        check("probe_data", probe_data_o, mk(8'h40, 8'h77));
        check("probe_stat", probe_stat_o, 2'b01);
        probe_tag_i = TW'('h41);
        #1;
        check("probe_miss_hit", probe_hit_o, 0);
        check("probe_miss_data", probe_data_o, 0);
        check("probe_miss_stat", probe_stat_o, 0);
        evict(8'h42, 8'h78, 2'b01);
        probe_tag_i = TW'('h42);
        #1;
        check("probe_same_cycle", probe_hit_o, 0);
        step();
        evict_v_i = 1'b0;
        check("probe_next_cycle", probe_hit_o, 1);
        probe_tag_i = TW'('h40);
        wb_ready_i  = 1'b1;
        #1;
        check("probe_deq_cycle", probe_hit_o, 1);
        step();
        wb_ready_i = 1'b0;
        check("probe_after_deq", probe_hit_o, 0);
        check("probe_left_count", count_o, 1);

        // Mid-operation reset discards queued lines
        evict(8'h70, 8'h01, 2'b01); step();
        evict_v_i = 1'b0;
        check("pre_rst_count", count_o, 2);
        #2;
        reset_n_i = 1'b0;
        #1;
        check("midrst_count", count_o, 0);
        check("midrst_wb_v", wb_v_o, 0);
        check("midrst_wb_tag", wb_tag_o, 0);
        check("midrst_probe", probe_hit_o, 0);
        @(negedge clk_i);
        reset_n_i  = 1'b1;
        wb_ready_i = 1'b1;
        step();
        check("postrst_empty", empty_o, 1);
        check("postrst_wb_v", wb_v_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
